// File: rtl/bpf_fetch.sv
// BPF instruction fetch: program counter, registered-ROM issue, tag tracking for the
// in-flight read, and a small prefetch FIFO feeding decode over valid/ready.
module bpf_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                INSN_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INSN_W-1:0] rom_data,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tag_pc;
  logic              inflight;

  logic [INSN_W-1:0] buf_insn [DEPTH];
  logic [ADDR_W-1:0] buf_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign insn_valid = (count != '0);
  assign insn       = buf_insn[rd_ptr];
  assign insn_pc    = buf_pc[rd_ptr];

  // A pop in a redirect cycle is void: the FIFO is being cleared anyway.
  assign pop  = insn_valid & insn_ready & ~redirect_valid;
  assign push = inflight & ~redirect_valid;

  // Entries that will be held after this edge; the next return must still fit.
  assign occupancy = ({1'b0, count} + OCC_W'(inflight)) - OCC_W'(pop);

  // rst_n gates the strobe so the ROM sees no reads while reset is held.
  assign issue    = rst_n & ~redirect_valid & (occupancy < OCC_W'(DEPTH));
  assign rom_en   = issue;
  assign rom_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        tag_pc   <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_insn[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_insn[wr_ptr] <= rom_data;
        buf_pc[wr_ptr]   <= tag_pc;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bpf_fetch.sv
// Bench for bpf_fetch: cycle table for reset/start/backpressure, directed redirect,
// wrap and mid-run reset sequences, then random traffic against a program-order model.
module tb_bpf_fetch;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [15:0] insn;
  logic [7:0]  insn_pc;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;

  always #5 clk = ~clk;

  bpf_fetch #(
    .ADDR_W  (8),
    .INSN_W  (16),
    .DEPTH   (2),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .insn_valid    (insn_valid),
    .insn_ready    (insn_ready),
    .insn          (insn),
    .insn_pc       (insn_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  logic [15:0] mem [256];
  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
  endtask

  // Reference model: accepted words must follow program order from the last
  // reset/redirect target, and the head must hold while stalled.
  logic [7:0]  sb_pc = RESET_PC;
  int          since_rd = 100;
  int          n_acc = 0;
  logic        p_hold = 1'b0;
  logic [15:0] p_insn;
  logic [7:0]  p_pc;

  task automatic drive(input logic rdy, input logic rv, input logic [7:0] rpc);
    insn_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    @(negedge clk);
    if (since_rd < 100) since_rd++;
    if (since_rd == 1 || since_rd == 2) chk("flush_gap_valid", insn_valid, 0);
    if (p_hold) begin
      chk("hold_valid", insn_valid, 1);
      chk("hold_insn", insn, p_insn);
      chk("hold_pc", insn_pc, p_pc);
    end
    if (insn_valid && insn_ready) begin
      chk("order_pc", insn_pc, sb_pc);
      chk("order_insn", insn, mem[sb_pc]);
      sb_pc++;
      n_acc++;
    end
    p_hold = insn_valid && !insn_ready && !rv;
    p_insn = insn;
    p_pc = insn_pc;
    if (rv) begin
      sb_pc = rpc;
      since_rd = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [7:0] rpc);
    drive(rdy, rv, rpc);
    tick();
  endtask

  typedef struct packed {
    logic        rdy;
    logic        en;
    logic [7:0]  addr;
    logic        vld;
    logic [15:0] ins;
    logic [7:0]  pc;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    logic [7:0] wp;

    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    mem[8'h40] = 16'h1234;

    tbl[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 8'h01, 1'b0, 16'h0000, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 8'h02, 1'b1, 16'hA000, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h03, 1'b1, 16'hA001, 8'h01};
    tbl[4]  = '{1'b0, 1'b0, 8'h03, 1'b1, 16'hA001, 8'h01};
    tbl[5]  = '{1'b0, 1'b0, 8'h03, 1'b1, 16'hA001, 8'h01};
    tbl[6]  = '{1'b0, 1'b0, 8'h03, 1'b1, 16'hA001, 8'h01};
    tbl[7]  = '{1'b0, 1'b0, 8'h03, 1'b1, 16'hA001, 8'h01};
    tbl[8]  = '{1'b1, 1'b1, 8'h03, 1'b1, 16'hA001, 8'h01};
    tbl[9]  = '{1'b1, 1'b1, 8'h04, 1'b1, 16'hA002, 8'h02};
    tbl[10] = '{1'b1, 1'b1, 8'h05, 1'b1, 16'hA003, 8'h03};
    tbl[11] = '{1'b1, 1'b1, 8'h06, 1'b1, 16'hA004, 8'h04};

    // Reset held
    insn_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_addr", rom_addr, RESET_PC);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_valid", insn_valid, 0);
    chk("rst_insn", insn, 0);
    chk("rst_insn_pc", insn_pc, 0);
    tick();
    rst_n = 1'b1;
    sb_pc = RESET_PC;

    // Start-up, streaming and backpressure, cycle by cycle
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rdy, 1'b0, 8'h00);
      chk($sformatf("tbl%0d_rom_en", i), rom_en, tbl[i].en);
      chk($sformatf("tbl%0d_rom_addr", i), rom_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), insn_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_insn", i), insn, tbl[i].ins);
        chk($sformatf("tbl%0d_pc", i), insn_pc, tbl[i].pc);
      end
      tick();
    end

    // Redirect coinciding with a pop and a returning word
    drive(1'b1, 1'b1, 8'h40);
    chk("rd_pop_same_cycle", insn_valid && insn_ready, 1);
    tick();
    drive(1'b1, 1'b0, 8'h00);
    chk("rd_t1_valid", insn_valid, 0);
    chk("rd_t1_rom_en", rom_en, 1);
    chk("rd_t1_rom_addr", rom_addr, 8'h40);
    tick();
    drive(1'b1, 1'b0, 8'h00);
    chk("rd_t2_valid", insn_valid, 0);
    tick();
    drive(1'b1, 1'b0, 8'h00);
    chk("rd_t3_valid", insn_valid, 1);
    chk("rd_t3_insn", insn, 16'h1234);
    chk("rd_t3_pc", insn_pc, 8'h40);
    tick();
    repeat (3) cyc(1'b1, 1'b0, 8'h00);

    // Wrap-around past 0xFF
    cyc(1'b1, 1'b1, 8'hFE);
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wp = 8'hFE + 8'(k);
      drive(1'b1, 1'b0, 8'h00);
      chk($sformatf("wrap%0d_valid", k), insn_valid, 1);
      chk($sformatf("wrap%0d_pc", k), insn_pc, wp);
      chk($sformatf("wrap%0d_insn", k), insn, 16'hA000 + 16'(wp));
      tick();
    end

    // Back-to-back redirects: last target wins
    cyc(1'b1, 1'b1, 8'h10);
    cyc(1'b1, 1'b1, 8'h20);
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    chk("b2b_valid", insn_valid, 1);
    chk("b2b_pc", insn_pc, 8'h20);
    chk("b2b_insn", insn, 16'hA020);
    tick();

    // Mid-run asynchronous reset with the FIFO full
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    chk("pre_rst_valid", insn_valid, 1);
    chk("pre_rst_rom_en", rom_en, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", insn_valid, 0);
    chk("mr_rom_en", rom_en, 0);
    chk("mr_rom_addr", rom_addr, RESET_PC);
    chk("mr_insn", insn, 0);
    p_hold = 1'b0;
    since_rd = 100;
    tick();
    rst_n = 1'b1;
    sb_pc = RESET_PC;
    drive(1'b1, 1'b0, 8'h00);
    chk("mr_c0_rom_en", rom_en, 1);
    chk("mr_c0_rom_addr", rom_addr, RESET_PC);
    tick();
    cyc(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    chk("mr_c2_valid", insn_valid, 1);
    chk("mr_c2_pc", insn_pc, RESET_PC);
    chk("mr_c2_insn", insn, mem[RESET_PC]);
    tick();

    // Random traffic
    a0 = n_acc;
    for (int i = 0; i < 2000; i++) begin
      cyc(logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 15) == 0),
          8'($urandom_range(0, 255)));
    end
    chk("rand_progress", (n_acc - a0) >= 500, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bpf_fetch.md
# bpf_fetch

Instruction fetch stage for the BPF CPU, sitting directly upstream of decode/operand-mux/ALU. It owns the program counter, drives the synchronous instruction ROM, and buffers returned instruction words in a small prefetch FIFO. The FIFO presents them downstream over a valid/ready handshake. It also accepts a PC redirect (jump/branch) from downstream, which flushes all buffered and in-flight fetches.

## Interface
- `ADDR_W`, default 8: PC / ROM address width.
- `INSN_W`, default 16: instruction word width (opcode[15:8], in1_idx[7:4], in2_idx[3:0]).
- `DEPTH`, default 2: prefetch FIFO entries; legal range is 2 to 8.
- `RESET_PC`, default 0: PC value loaded at reset.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `rom_en  out  1`: fetch issue strobe this cycle.
- `rom_addr  out  ADDR_W`: ROM address. Equals the internal fetch PC at all times.
- `rom_data  in  INSN_W`: ROM read data. Valid exactly one cycle after an issue (registered ROM).
- `insn_valid  out  1`: FIFO head is valid.
- `insn_ready  in  1`: downstream accepts the head this cycle.
- `insn  out  INSN_W`: head instruction word.
- `insn_pc  out  ADDR_W`: address the head word was fetched from.
- `redirect_valid  in  1`: load a new PC and flush.
- `redirect_pc  in  ADDR_W`: target PC.

## Operation
- Reset (async assert) sets the following:
  - fetch_pc = RESET_PC, so rom_addr = RESET_PC.
  - rom_en = 0, inflight = 0, FIFO count = 0.
  - insn_valid = 0, insn = 0, insn_pc = 0.
- Pop occurs when insn_valid && insn_ready. The head is removed at the clock edge.
- Issue rule: rom_en = !redirect_valid && (count − pop + inflight) < DEPTH.
  - On issue, fetch_pc increments by 1 modulo 2^ADDR_W, so 0xFF wraps to 0x00.
  - inflight is set for the next cycle and cleared otherwise.
  - Each in-flight fetch carries its PC in a tag register.
- Return: in the cycle after an issue, rom_data and the tagged PC are pushed into the FIFO.
  - This push is skipped if redirect_valid is high in that cycle.
  - The issue rule guarantees the push never overflows, including simultaneous push and pop.
- Redirect has the highest priority. In a redirect cycle:
  - The FIFO is cleared and any pop that cycle is void.
  - The returning rom_data is discarded.
  - No issue occurs.
  - fetch_pc is loaded with redirect_pc.
- FIFO ordering is strictly in program order. Head outputs are stable while insn_valid && !insn_ready.
- No combinational path from insn_ready to insn_valid. insn_ready does feed rom_en combinationally, which is permitted.

## Timing
- First fetch after reset release: rom_en = 1 with rom_addr = RESET_PC in cycle 0. Data arrives in cycle 1, and insn_valid = 1 in cycle 2.
- Steady state with insn_ready held high and DEPTH ≥ 2: one instruction per cycle, no bubbles.
- Backpressure (insn_ready = 0):
  - Fetch stops once count + inflight = DEPTH.
  - Issue resumes in the same cycle the pop happens.
- Redirect asserted in cycle T:
  - insn_valid = 0 in cycles T+1 and T+2.
  - rom_addr = redirect_pc with rom_en = 1 in T+1.
  - insn = mem[redirect_pc] valid in T+3.
- Back-to-back redirects: the last one wins. Each restarts the T+3 latency.
- Reset asserted mid-operation: outputs go to reset values immediately. The in-flight response is lost, and after release the fetch restarts at RESET_PC.

## Test plan
- **Reset and start:** hold rst_n low, preload ROM mem[i] = 16'hA000 + i, release with insn_ready = 1.
  - Required: rom_addr = 0 while in reset.
  - Required: insn = A000 / pc 0 in cycle 2, then A001 and A002 in consecutive cycles with no gaps.
- **Backpressure:** drop insn_ready for 5 cycles after the first accept.
  - Required: rom_en stays low once 2 entries are buffered.
  - Required: insn is held at A001.
  - Required: after re-raising insn_ready, the sequence A001, A002, A003 continues with no loss or duplication.
- **Redirect:** assert redirect_valid with redirect_pc = 8'h40 for one cycle during streaming, with mem[0x40] = 16'h1234.
  - Required: insn_valid is low for 2 cycles, then insn = 1234 / pc 0x40.
  - Required: no pre-redirect word appears after the redirect.
- **Redirect with simultaneous pop and return:** assert redirect while insn_valid && insn_ready.
  - Required: the popped word is counted as consumed.
  - Required: the returning word is dropped.
  - Required: exactly one accept of mem[target] follows.
- **Wrap-around:** redirect to 8'hFE.
  - Required: accepted pcs are FE, FF, 00, 01 with the matching words.
- **Mid-run reset:** assert rst_n low asynchronously between clock edges while 2 entries are buffered.
  - Required: insn_valid = 0 immediately.
  - Required: after release, the first accepted word is mem[RESET_PC].
